// File: rtl/logic_grid_cfg.sv
// logic_grid_cfg: a row of logic columns, west (0) to east (COLUMNS-1), plus a
// word-oriented loader that serialises configuration into the column chains.
//
// Ports:
//   clock, reset                  sole clock, asynchronous active-high reset
//   data_{north,south}_{in,out}   COLUMNS*IO_PER_COLUMN, column c on [c*IO +: IO]
//   data_{west,east}_{in,out}     EW_WIDTH, grid edge buses (col 0 west, last col east)
//   cfg_start/cfg_all/cfg_column  start a load of the whole grid or one column
//   cfg_valid/cfg_data/cfg_ready  configuration word handshake
//   busy, done, error             loader status (done/error are one-cycle pulses)
//   config_out                    config chain output of the east-most column

// One grid column: a config shift chain plus simple configured user logic.
//   north_out = south_in ^ cfg mask (combinational)
//   south_out = north_in, registered
//   east_out  = west_in ^ cfg mask, registered
//   west_out  = east_in, registered
// User flops are cleared by nreset, the config chain by config_nreset.
module logic_column #(
  parameter int IO_W     = 10,
  parameter int EW_W     = 80,
  parameter int CFG_BITS = 64
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            config_nreset,
  input  logic            config_enable,
  input  logic            config_in,
  output logic            config_out,
  input  logic [IO_W-1:0] north_in,
  input  logic [IO_W-1:0] south_in,
  output logic [IO_W-1:0] north_out,
  output logic [IO_W-1:0] south_out,
  input  logic [EW_W-1:0] west_in,
  input  logic [EW_W-1:0] east_in,
  output logic [EW_W-1:0] west_out,
  output logic [EW_W-1:0] east_out
);
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [IO_W-1:0]     ns_mask, south_q, south_d;
  logic [EW_W-1:0]     ew_mask, east_q, east_d, west_q, west_d;

  // Masks wrap around the config word when the bus is wider than the chain.
  for (genvar i = 0; i < IO_W; i++) begin : g_ns_mask
    assign ns_mask[i] = cfg_q[i % CFG_BITS];
  end
  for (genvar i = 0; i < EW_W; i++) begin : g_ew_mask
    assign ew_mask[i] = cfg_q[i % CFG_BITS];
  end

  // Bits enter at the top and leave from bit 0, so the first bit of a
  // chain load ends up in bit 0 of the furthest column.
  always_comb begin
    cfg_d = cfg_q;
    if (config_enable) cfg_d = {config_in, cfg_q[CFG_BITS-1:1]};
    south_d = north_in;
    east_d  = west_in ^ ew_mask;
    west_d  = east_in;
  end

  always_ff @(posedge clock or negedge config_nreset) begin
    if (!config_nreset) cfg_q <= '0;
    else                cfg_q <= cfg_d;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      south_q <= '0;
      east_q  <= '0;
      west_q  <= '0;
    end else begin
      south_q <= south_d;
      east_q  <= east_d;
      west_q  <= west_d;
    end
  end

  assign config_out = cfg_q[0];
  assign north_out  = south_in ^ ns_mask;
  assign south_out  = south_q;
  assign east_out   = east_q;
  assign west_out   = west_q;
endmodule

module logic_grid_cfg #(
  parameter int  COLUMNS         = 8,
  parameter int  IO_PER_COLUMN   = 10,
  parameter int  EW_WIDTH        = 80,
  parameter int  COLUMN_CFG_BITS = 64,
  parameter int  CFG_WORD        = 32,
  localparam int CW              = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [COLUMNS*IO_PER_COLUMN-1:0] data_north_in,
  output logic [COLUMNS*IO_PER_COLUMN-1:0] data_north_out,
  input  logic [COLUMNS*IO_PER_COLUMN-1:0] data_south_in,
  output logic [COLUMNS*IO_PER_COLUMN-1:0] data_south_out,
  input  logic [EW_WIDTH-1:0]              data_west_in,
  output logic [EW_WIDTH-1:0]              data_west_out,
  input  logic [EW_WIDTH-1:0]              data_east_in,
  output logic [EW_WIDTH-1:0]              data_east_out,
  input  logic                             cfg_start,
  input  logic                             cfg_all,
  input  logic [CW-1:0]                    cfg_column,
  input  logic                             cfg_valid,
  input  logic [CFG_WORD-1:0]              cfg_data,
  output logic                             cfg_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic                             config_out
);
  localparam int TOTAL_BITS = COLUMNS * COLUMN_CFG_BITS;
  localparam int RW         = $clog2(TOTAL_BITS + 1);
  localparam int BW         = (CFG_WORD > 1) ? $clog2(CFG_WORD) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CFG_WORD-1:0] shift_q, shift_d;
  logic [RW-1:0]       remaining_q, remaining_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                all_q, all_d;
  logic [CW-1:0]       target_q, target_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    bit_cnt_d   = bit_cnt_q;
    all_d       = all_q;
    target_d    = target_q;
    error_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (!cfg_all && (32'(cfg_column) >= COLUMNS)) begin
            error_d = 1'b1;
          end else begin
            all_d       = cfg_all;
            target_d    = cfg_column;
            remaining_d = cfg_all ? RW'(TOTAL_BITS) : RW'(COLUMN_CFG_BITS);
            state_d     = WAIT_WORD;
          end
        end
      end
      WAIT_WORD: begin
        if (cfg_valid) begin
          shift_d   = cfg_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d     = {1'b0, shift_q[CFG_WORD-1:1]};
        remaining_d = remaining_q - 1'b1;
        bit_cnt_d   = bit_cnt_q + 1'b1;
        // Running out of bits wins over the word boundary; leftover bits
        // of a partially used word are simply dropped.
        if (remaining_q == RW'(1))                 state_d = DONE;
        else if (bit_cnt_q == BW'(CFG_WORD - 1))   state_d = WAIT_WORD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered copies of the next-state decode.
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == WAIT_WORD);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      remaining_q <= '0;
      bit_cnt_q   <= '0;
      all_q       <= 1'b0;
      target_q    <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      bit_cnt_q   <= bit_cnt_d;
      all_q       <= all_d;
      target_q    <= target_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  // Column fabric
  logic [COLUMNS-1:0]               col_en, col_in, col_out;
  logic [COLUMNS-1:0][EW_WIDTH-1:0] col_w_in, col_w_out, col_e_in, col_e_out;
  logic                             col_nreset, col_cfg_nreset, shifting;

  // User logic stays in reset for the whole load.
  assign col_nreset     = ~reset & ~busy_q;
  assign col_cfg_nreset = ~reset;
  assign shifting       = (state_q == SHIFT);

  for (genvar c = 0; c < COLUMNS; c++) begin : g_col
    logic sel;
    assign sel       = ~all_q & (target_q == CW'(c));
    assign col_en[c] = shifting & (all_q | sel);

    if (c == 0) begin : g_west_edge
      assign col_in[c]   = shift_q[0];
      assign col_w_in[c] = data_west_in;
    end else begin : g_west_link
      assign col_in[c]   = sel ? shift_q[0] : col_out[c-1];
      assign col_w_in[c] = col_e_out[c-1];
    end

    if (c == COLUMNS - 1) begin : g_east_edge
      assign col_e_in[c] = data_east_in;
    end else begin : g_east_link
      assign col_e_in[c] = col_w_out[c+1];
    end

    logic_column #(
      .IO_W     (IO_PER_COLUMN),
      .EW_W     (EW_WIDTH),
      .CFG_BITS (COLUMN_CFG_BITS)
    ) u_col (
      .clock         (clock),
      .nreset        (col_nreset),
      .config_nreset (col_cfg_nreset),
      .config_enable (col_en[c]),
      .config_in     (col_in[c]),
      .config_out    (col_out[c]),
      .north_in      (data_north_in[c*IO_PER_COLUMN +: IO_PER_COLUMN]),
      .south_in      (data_south_in[c*IO_PER_COLUMN +: IO_PER_COLUMN]),
      .north_out     (data_north_out[c*IO_PER_COLUMN +: IO_PER_COLUMN]),
      .south_out     (data_south_out[c*IO_PER_COLUMN +: IO_PER_COLUMN]),
      .west_in       (col_w_in[c]),
      .east_in       (col_e_in[c]),
      .west_out      (col_w_out[c]),
      .east_out      (col_e_out[c])
    );
  end

  assign data_west_out = col_w_out[0];
  assign data_east_out = col_e_out[COLUMNS-1];
  assign config_out    = col_out[COLUMNS-1];
endmodule

// File: tb/tb_logic_grid_cfg.sv
// Bench for logic_grid_cfg: a default-sized grid (A) and a 6-column, 40-bit
// chain grid (B). Expected shift bits are queued as words are offered and
// popped by a monitor on every config_enable cycle.
module tb_logic_grid_cfg;
  localparam int COLS = 8, IO = 10, EW = 80, CB = 64, WD = 32;
  localparam int B_COLS = 6, B_CB = 40;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // grid A
  logic [COLS*IO-1:0] a_n_in, a_n_out, a_s_in, a_s_out;
  logic [EW-1:0]      a_w_in, a_w_out, a_e_in, a_e_out;
  logic               a_start, a_all, a_valid, a_ready, a_busy, a_done, a_error, a_cfg_out;
  logic [2:0]         a_col;
  logic [WD-1:0]      a_data;
  // grid B
  logic [B_COLS*IO-1:0] b_n_in, b_n_out, b_s_in, b_s_out;
  logic [EW-1:0]        b_w_in, b_w_out, b_e_in, b_e_out;
  logic                 b_start, b_all, b_valid, b_ready, b_busy, b_done, b_error, b_cfg_out;
  logic [2:0]           b_col;
  logic [WD-1:0]        b_data;

  logic_grid_cfg dut_a (
    .clock(clock), .reset(reset),
    .data_north_in(a_n_in), .data_north_out(a_n_out),
    .data_south_in(a_s_in), .data_south_out(a_s_out),
    .data_west_in(a_w_in), .data_west_out(a_w_out),
    .data_east_in(a_e_in), .data_east_out(a_e_out),
    .cfg_start(a_start), .cfg_all(a_all), .cfg_column(a_col),
    .cfg_valid(a_valid), .cfg_data(a_data), .cfg_ready(a_ready),
    .busy(a_busy), .done(a_done), .error(a_error), .config_out(a_cfg_out)
  );

  logic_grid_cfg #(.COLUMNS(B_COLS), .COLUMN_CFG_BITS(B_CB)) dut_b (
    .clock(clock), .reset(reset),
    .data_north_in(b_n_in), .data_north_out(b_n_out),
    .data_south_in(b_s_in), .data_south_out(b_s_out),
    .data_west_in(b_w_in), .data_west_out(b_w_out),
    .data_east_in(b_e_in), .data_east_out(b_e_out),
    .cfg_start(b_start), .cfg_all(b_all), .cfg_column(b_col),
    .cfg_valid(b_valid), .cfg_data(b_data), .cfg_ready(b_ready),
    .busy(b_busy), .done(b_done), .error(b_error), .config_out(b_cfg_out)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [COLS-1:0] en; int col; logic b; } shift_exp_t;
  shift_exp_t    sq[$];
  shift_exp_t    mon_e;
  logic [WD-1:0] words[$];
  logic [1023:0] stream;
  int            slen;
  logic [CB-1:0] model[COLS];

  // Scoreboard monitor for grid A: every enabled cycle must match the next
  // queued bit; loading also keeps the user logic (south path) in reset.
  always @(negedge clock) begin
    if (!reset && dut_a.col_en != '0) begin
      if (sq.size() == 0) chk("unexpected_shift", 128'(dut_a.col_en), 128'(0));
      else begin
        mon_e = sq.pop_front();
        chk("shift_en", 128'(dut_a.col_en), 128'(mon_e.en));
        chk("shift_bit", 128'(dut_a.col_in[mon_e.col]), 128'(mon_e.b));
      end
    end
    if (!reset && a_busy) chk("south_held", 128'(a_s_out), 128'(0));
  end

  task automatic check_a_idle(input string tag);
    chk({tag, "_busy"},  128'(a_busy),  128'(0));
    chk({tag, "_ready"}, 128'(a_ready), 128'(0));
    chk({tag, "_done"},  128'(a_done),  128'(0));
    chk({tag, "_error"}, 128'(a_error), 128'(0));
    chk({tag, "_en"},    128'(dut_a.col_en), 128'(0));
  endtask

  // Run one load on grid A; optionally delay cfg_valid, poke cfg_start
  // mid-shift, or assert reset after abort_after enabled cycles.
  task automatic run_a(input logic all, input int col, input int delay,
                       input int abort_after, input bit poke);
    int rem, nbits, nwords, wi, wait_cnt, en_cnt, ready_cnt, bub_cnt, done_cnt, last_en, done_at, n;
    bit seen_en;
    logic [COLS-1:0] m;
    m = all ? '1 : COLS'(1) << col;
    nbits = all ? COLS*CB : CB;
    nwords = (nbits + WD - 1) / WD;
    rem = nbits; slen = 0; wi = 0; wait_cnt = 0; en_cnt = 0; ready_cnt = 0;
    bub_cnt = 0; done_cnt = 0; last_en = -1; done_at = -1; seen_en = 0;
    a_start = 1; a_all = all; a_col = 3'(col); a_valid = 0;
    @(negedge clock);
    a_start = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      a_start = 0; a_all = all;
      if (dut_a.col_en != '0) begin
        en_cnt++; last_en = cyc; seen_en = 1;
        if (poke && en_cnt == 3) begin a_start = 1; a_all = ~all; end
        if (abort_after != 0 && en_cnt == abort_after) begin
          #2 reset = 1;
          #1 check_a_idle("abort");
          chk("abort_cfg_out", 128'(a_cfg_out), 128'(0));
          chk("abort_south", 128'(a_s_out), 128'(0));
          sq.delete();
          for (int c = 0; c < COLS; c++) model[c] = '0;
          a_valid = 0;
          @(negedge clock);
          check_a_idle("abort_hold");
          reset = 0;
          return;
        end
      end
      if (a_done) begin done_cnt++; done_at = cyc; break; end
      if (a_ready) begin
        ready_cnt++;
        if (seen_en) bub_cnt++;
        if (wait_cnt < delay) begin a_valid = 0; wait_cnt++; end
        else if (wi >= words.size()) begin
          chk("word_underflow", 128'(wi), 128'(words.size()));
          a_valid = 0;
        end else begin
          a_valid = 1; a_data = words[wi];
          n = (rem < WD) ? rem : WD;
          for (int j = 0; j < n; j++) begin
            shift_exp_t e;
            e.en = m; e.col = all ? 0 : col; e.b = words[wi][j];
            sq.push_back(e);
            stream[slen] = words[wi][j]; slen++;
          end
          rem -= n; wi++; wait_cnt = 0;
        end
      end
      @(negedge clock);
    end
    a_start = 0; a_all = all;
    chk("done_pulses", 128'(done_cnt), 128'(1));
    chk("en_cycles", 128'(en_cnt), 128'(nbits));
    chk("ready_cycles", 128'(ready_cnt), 128'(nwords*(delay+1)));
    chk("bubbles", 128'(bub_cnt), 128'((nwords-1)*(delay+1)));
    chk("done_after_last_bit", 128'(done_at), 128'(last_en + 1));
    chk("queue_drained", 128'(sq.size()), 128'(0));
    @(negedge clock);
    a_valid = 0;
    check_a_idle("after_done");
    if (all) for (int c = 0; c < COLS; c++) model[c] = stream[CB*(COLS-1-c) +: CB];
    else model[col] = stream[CB-1:0];
  endtask

  // Once settled, the user paths reveal the column configuration.
  task automatic check_a_data(input string tag);
    logic [EW-1:0] ex;
    repeat (12) @(negedge clock);
    ex = a_w_in;
    for (int c = 0; c < COLS; c++) begin
      chk({tag, "_north"}, 128'(a_n_out[c*IO +: IO]), 128'(model[c][IO-1:0] ^ a_s_in[c*IO +: IO]));
      for (int i = 0; i < EW; i++) ex[i] = ex[i] ^ model[c][i % CB];
    end
    chk({tag, "_east"}, 128'(a_e_out), 128'(ex));
    chk({tag, "_west"}, 128'(a_w_out), 128'(a_e_in));
    chk({tag, "_south"}, 128'(a_s_out), 128'(a_n_in));
    chk({tag, "_cfg_out"}, 128'(a_cfg_out), 128'(model[COLS-1][0]));
  endtask

  logic [WD-1:0] bw[3];
  int b_acc, b_en;
  bit b_seen_done;

  initial begin
    reset = 1;
    a_start = 0; a_all = 0; a_col = 0; a_valid = 0; a_data = 0;
    b_start = 0; b_all = 0; b_col = 0; b_valid = 0; b_data = 0;
    a_n_in = {8{10'h2B5}}; a_s_in = '0;
    a_w_in = 80'h1234_5678_9ABC_DEF0_5A5A; a_e_in = 80'hCAFE_0000_BEEF_1111_2222;
    b_n_in = {6{10'h155}}; b_s_in = '0; b_w_in = '0; b_e_in = '0;
    for (int c = 0; c < COLS; c++) model[c] = '0;
    repeat (2) @(negedge clock);
    check_a_idle("reset");
    chk("reset_cfg_out", 128'(a_cfg_out), 128'(0));
    chk("reset_south", 128'(a_s_out), 128'(0));
    chk("reset_east", 128'(a_e_out), 128'(0));
    chk("reset_b_busy", 128'(b_busy), 128'(0));
    chk("reset_b_ready", 128'(b_ready), 128'(0));
    reset = 0;

    // Full grid load, valid held high
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(32'(32'h9E3779B9 * (i + 1)));
    run_a(1'b1, 0, 0, 0, 1'b0);
    check_a_data("full");

    // Single column 3
    words.delete();
    words.push_back(32'hA5A5A5A5); words.push_back(32'h0F0F0F0F);
    run_a(1'b0, 3, 0, 0, 1'b0);
    check_a_data("col3");

    // Delayed valid with a cfg_start poke during SHIFT
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(32'hC3000000 ^ (32'(i) * 32'h01030507));
    run_a(1'b1, 0, 5, 0, 1'b1);
    check_a_data("delay");

    // Reset after 100 shift cycles, then an immediate full reload
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(32'h600DF00D + 32'(i));
    run_a(1'b1, 0, 0, 100, 1'b0);
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back(32'h0BADC0DE ^ (32'(i) << 4));
    run_a(1'b1, 0, 0, 0, 1'b0);
    check_a_data("reload");

    // Grid B: out-of-range column rejected
    b_start = 1; b_all = 0; b_col = 3'd6;
    @(negedge clock);
    b_start = 0;
    chk("b_err_pulse", 128'(b_error), 128'(1));
    chk("b_err_busy", 128'(b_busy), 128'(0));
    chk("b_err_ready", 128'(b_ready), 128'(0));
    @(negedge clock);
    chk("b_err_clear", 128'(b_error), 128'(0));
    chk("b_err_busy2", 128'(b_busy), 128'(0));
    chk("b_err_ready2", 128'(b_ready), 128'(0));

    // Grid B: 40-bit chain on column 5, second word cut after 8 bits
    bw[0] = 32'h123456A7; bw[1] = 32'hFEDCBA98; bw[2] = 32'h55AA55AA;
    b_start = 1; b_all = 0; b_col = 3'd5; b_valid = 1; b_data = bw[0];
    @(negedge clock);
    b_start = 0; b_acc = 0; b_en = 0; b_seen_done = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (dut_b.col_en != '0) begin
        chk("b_en_mask", 128'(dut_b.col_en), 128'(6'b100000));
        chk("b_bit", 128'(dut_b.col_in[5]), 128'((b_en < 32) ? bw[0][b_en] : bw[1][b_en - 32]));
        b_en++;
      end
      if (b_done) begin b_seen_done = 1; break; end
      if (b_ready) begin
        b_data = bw[(b_acc < 3) ? b_acc : 2];
        b_acc++;
      end
      @(negedge clock);
    end
    chk("b_done_seen", 128'(b_seen_done), 128'(1));
    chk("b_words", 128'(b_acc), 128'(2));
    chk("b_en_cycles", 128'(b_en), 128'(B_CB));
    b_data = bw[2];
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("b_third_ready", 128'(b_ready), 128'(0));
      chk("b_third_busy", 128'(b_busy), 128'(0));
    end
    b_valid = 0;
    chk("b_north5", 128'(b_n_out[5*IO +: IO]), 128'(bw[0][IO-1:0]));
    chk("b_cfg_out", 128'(b_cfg_out), 128'(bw[0][0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_grid_cfg.md
LOGIC_GRID_CFG -- requirements
Module: logic_grid_cfg

Interface
Parameters:
REQ-001 SHALL have parameter COLUMNS, default 8: number of LogicColumn instances, index 0 = west, COLUMNS-1 = east.
REQ-002 SHALL have parameter IO_PER_COLUMN, default 10: north/south bits per column.
REQ-003 SHALL have parameter EW_WIDTH, default 80: east/west bus width of every column.
REQ-004 SHALL have parameter COLUMN_CFG_BITS, default 64: config chain length of one column.
REQ-005 SHALL have parameter CFG_WORD, default 32: config loader word width.

Ports:
REQ-006 SHALL have: clock  in  1  sole clock; reset  in  1  asynchronous, active-high.
REQ-007 SHALL have: data_north_in/out, data_south_in/out  in/out  COLUMNS*IO_PER_COLUMN  column c on slice [c*IO_PER_COLUMN +: IO_PER_COLUMN].
REQ-008 SHALL have: data_west_in/out, data_east_in/out  in/out  EW_WIDTH  column 0 west side, column COLUMNS-1 east side; adjacent columns cross-connected east<->west.
REQ-009 SHALL have: cfg_start  in  1  begin load; cfg_all  in  1  1 = whole grid, 0 = single column; cfg_column  in  $clog2(COLUMNS) (min 1)  target column.
REQ-010 SHALL have: cfg_valid  in  1; cfg_data  in  CFG_WORD; cfg_ready  out  1  word handshake.
REQ-011 SHALL have: busy  out  1; done  out  1  one-cycle pulse; error  out  1  one-cycle pulse; config_out  out  1  config_out of column COLUMNS-1.

Function
REQ-012 SHALL use FSM states IDLE, WAIT_WORD, SHIFT, DONE, with busy=1 in every state except IDLE.
REQ-013 IDLE: cfg_start=1 with cfg_all=0 and cfg_column>=COLUMNS SHALL pulse error for one cycle and stay in IDLE.
REQ-014 IDLE: otherwise cfg_start=1 SHALL latch target/mode, set remaining = COLUMNS*COLUMN_CFG_BITS (all) or COLUMN_CFG_BITS (single), and enter WAIT_WORD next cycle.
REQ-015 cfg_start SHALL be ignored when not in IDLE.
REQ-016 cfg_ready SHALL be 1 only in WAIT_WORD; a word SHALL be accepted on cfg_valid&cfg_ready, loaded into the shifter, with transition to SHIFT.
REQ-017 SHIFT SHALL emit one bit per cycle, LSB first, starting the cycle after acceptance, decrementing remaining each cycle.
REQ-018 All mode: columns SHALL be daisy-chained (column c config_in = column c-1 config_out); the shifter drives column 0; config_enable=1 on all columns during SHIFT.
REQ-019 Single mode: the shifter SHALL drive only the target column's config_in, with config_enable=1 only on that column during SHIFT and all other columns' config_enable=0.
REQ-020 After CFG_WORD shifted bits with remaining>0, the FSM SHALL return to WAIT_WORD (one bubble cycle per word).
REQ-021 When remaining reaches 0, including mid-word, the FSM SHALL go to DONE immediately, discarding unshifted bits of that word.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Column config_enable SHALL be 0 outside SHIFT.
REQ-024 Column nreset SHALL be ~reset & ~busy (user logic held in reset during loading).
REQ-025 Column config_nreset SHALL be ~reset.

Reset
REQ-026 reset=1 SHALL asynchronously force IDLE, zero the shifter and counters, and drive cfg_ready=0, busy=0, done=0, error=0, all column config_enable=0.
REQ-027 Reset mid-load SHALL abort with no done pulse; column config is cleared via config_nreset; a new cfg_start is accepted on the first cycle after reset deasserts.

Verification
REQ-028 Full load, defaults: cfg_start, cfg_all=1, 16 words streamed with cfg_valid held 1 -> 512 config_enable cycles across all columns, 15 bubble cycles, done one cycle after final bit, busy=0 afterwards.
REQ-029 Single column, cfg_column=3, words 0xA5A5A5A5 and 0x0F0F0F0F -> only column 3 config_enable high for 64 cycles, its config_in sequence = 1,0,1,0,0,1,0,1,... LSB first.
REQ-030 COLUMNS=6, cfg_all=0, cfg_column=6 -> error pulse 1 cycle, busy stays 0, cfg_ready stays 0.
REQ-031 COLUMN_CFG_BITS=40, single mode -> 2 words accepted, second word shifts 8 bits then DONE; a third cfg_valid is not accepted.
REQ-032 cfg_valid delayed 5 cycles in WAIT_WORD -> cfg_ready held 1, no shifting; cfg_start pulsed during SHIFT ignored.
REQ-033 reset asserted after 100 shift cycles of a full load -> all outputs at reset values same cycle, no done pulse; a following full load completes normally.
